// File: rtl/pwm_ramp_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pwm_ramp_if : request/grant and duty-level bundle for pwm_ramp_controller
// Revision    : 1.0
// ----------------------------------------------------------------------------
interface pwm_ramp_if;
  logic       req_a;
  logic [1:0] lvl_a;
  logic       req_b;
  logic [1:0] lvl_b;
  logic       ack_a;
  logic       ack_b;
  logic [1:0] mode;
  logic       busy;
  logic       done;

  modport master (
    output req_a, lvl_a, req_b, lvl_b,
    input  ack_a, ack_b, mode, busy, done
  );

  modport slave (
    input  req_a, lvl_a, req_b, lvl_b,
    output ack_a, ack_b, mode, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/pwm_ramp_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pwm_ramp_controller : round-robin level arbiter that ramps PWM mode by one
//                       step per STEP_PERIODS periods, only on period wraps
// Revision            : 1.0
// ----------------------------------------------------------------------------
module pwm_ramp_controller #(
  parameter int PERIOD       = 32,
  parameter int STEP_PERIODS = 4
) (
  input  logic      clk,
  input  logic      rst,
  pwm_ramp_if.slave bus
);

  localparam int             PCW       = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [PCW-1:0] PCNT_LAST = PCW'(PERIOD - 1);
  localparam logic [7:0]     SCNT_LAST = 8'(STEP_PERIODS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_RAMP  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [PCW-1:0] pcnt_q, pcnt_d;
  logic [7:0]     scnt_q, scnt_d;
  logic [1:0]     mode_q, mode_d;
  logic [1:0]     target_q, target_d;
  logic           rr_q, rr_d;
  logic           ack_a_q, ack_a_d;
  logic           ack_b_q, ack_b_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           boundary;
  logic           pick_b;

  assign boundary = (pcnt_q == PCNT_LAST);
  assign pcnt_d   = boundary ? '0 : pcnt_q + PCW'(1);

  always_comb begin
    state_d  = state_q;
    scnt_d   = scnt_q;
    mode_d   = mode_q;
    target_d = target_q;
    rr_d     = rr_q;
    ack_a_d  = 1'b0;
    ack_b_d  = 1'b0;
    pick_b   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req_a || bus.req_b) begin
          // rr_q set means B wins a tie; it only moves on a tie
          pick_b = bus.req_b && (!bus.req_a || rr_q);
          if (bus.req_a && bus.req_b) begin
            rr_d = ~pick_b;
          end
          target_d = pick_b ? bus.lvl_b : bus.lvl_a;
          ack_a_d  = ~pick_b;
          ack_b_d  = pick_b;
          scnt_d   = '0;
          state_d  = S_GRANT;
        end
      end

      S_GRANT: begin
        state_d = (target_q == mode_q) ? S_DONE : S_RAMP;
      end

      S_RAMP: begin
        if (boundary) begin
          if (scnt_q == SCNT_LAST) begin
            scnt_d = '0;
            if ((target_q > mode_q) && (mode_q != 2'd3)) begin
              mode_d = mode_q + 2'd1;
            end else if ((target_q < mode_q) && (mode_q != 2'd0)) begin
              mode_d = mode_q - 2'd1;
            end
            if (mode_d == target_q) begin
              state_d = S_DONE;
            end
          end else begin
            scnt_d = scnt_q + 8'd1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pcnt_q   <= '0;
      scnt_q   <= '0;
      mode_q   <= 2'd0;
      target_q <= 2'd0;
      rr_q     <= 1'b0;
      ack_a_q  <= 1'b0;
      ack_b_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      scnt_q   <= scnt_d;
      mode_q   <= mode_d;
      target_q <= target_d;
      rr_q     <= rr_d;
      ack_a_q  <= ack_a_d;
      ack_b_q  <= ack_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.ack_a = ack_a_q;
  assign bus.ack_b = ack_b_q;
  assign bus.mode  = mode_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_ramp_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pwm_ramp_controller : directed scenarios plus random requests, compared
//                          every cycle against a transaction-schedule model
// Revision               : 1.0
// ----------------------------------------------------------------------------
module tb_pwm_ramp_controller;

  localparam int P  = 32;
  localparam int SP = 4;

  logic       clk = 1'b0;
  logic       rst_in;
  logic       ra, rb;
  logic [1:0] la, lb;

  always #5 clk = ~clk;

  pwm_ramp_if bus_if ();

  assign bus_if.req_a = ra;
  assign bus_if.lvl_a = la;
  assign bus_if.req_b = rb;
  assign bus_if.lvl_b = lb;

  pwm_ramp_controller #(.PERIOD(P), .STEP_PERIODS(SP)) dut (
    .clk (clk),
    .rst (rst_in),
    .bus (bus_if)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit rst_prev = 1'b0;

  // Model: one record per granted transaction, with cycle numbers counted from
  // the first cycle after reset (period counter is cyc % P in that cycle).
  bit m_rr;      // 1: a tie goes to B
  int m_free;    // first cycle in which the controller samples requests
  bit t_valid;
  bit t_b;
  int t_g;       // sampling cycle; ack is in t_g+1
  int t_start, t_target, t_k, t_b0, t_done;

  function automatic int steps_seen(int x);
    int num;
    if (!t_valid || t_k == 0) return 0;
    num = x - t_b0 - 1 + P;
    if (num < 0) return 0;
    num = num / (SP * P);
    return (num > t_k) ? t_k : num;
  endfunction

  function automatic int exp_mode(int x);
    if (!t_valid) return 0;
    return (t_target >= t_start) ? t_start + steps_seen(x) : t_start - steps_seen(x);
  endfunction

  task automatic model_reset();
    m_rr    = 1'b0;
    m_free  = 0;
    t_valid = 1'b0;
    t_b     = 1'b0;
    t_g     = -10;
    t_done  = -10;
    t_k     = 0;
    t_b0    = 0;
    t_start = 0;
    t_target = 0;
  endtask

  task automatic model_sample(int c);
    bit both, win_b;
    int st, tg, k, b0;
    if (c >= m_free && (ra || rb)) begin
      both  = ra && rb;
      win_b = both ? m_rr : rb;
      if (both) m_rr = !m_rr;
      st = exp_mode(c);
      tg = win_b ? int'(lb) : int'(la);
      k  = (tg > st) ? tg - st : st - tg;
      // first boundary cycle strictly after the GRANT cycle
      b0 = c + 2 + (P - 1 - ((c + 2) % P));
      t_valid  = 1'b1;
      t_b      = win_b;
      t_g      = c;
      t_start  = st;
      t_target = tg;
      t_k      = k;
      t_b0     = b0;
      t_done   = (k == 0) ? c + 2 : b0 + (k * SP - 1) * P + 1;
      m_free   = t_done + 1;
    end
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    bit e_ack_a, e_ack_b, e_busy, e_done;
    if (!rst_in) model_sample(cyc);
    rst_prev = rst_in;
    @(posedge clk);
    #1;
    if (rst_prev) begin
      model_reset();
      cyc = 0;
    end else begin
      cyc++;
    end
    e_ack_a = t_valid && !t_b && (cyc == t_g + 1);
    e_ack_b = t_valid &&  t_b && (cyc == t_g + 1);
    e_busy  = t_valid && (cyc > t_g) && (cyc <= t_done);
    e_done  = t_valid && (cyc == t_done);
    check_eq("mode",  32'(bus_if.mode),  32'(exp_mode(cyc)));
    check_eq("ack_a", 32'(bus_if.ack_a), 32'(e_ack_a));
    check_eq("ack_b", 32'(bus_if.ack_b), 32'(e_ack_b));
    check_eq("busy",  32'(bus_if.busy),  32'(e_busy));
    check_eq("done",  32'(bus_if.done),  32'(e_done));
    // requesters release once they see their grant
    if (e_ack_a) ra = 1'b0;
    if (e_ack_b) rb = 1'b0;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    model_reset();
    rst_in = 1'b1;
    ra = 1'b0; rb = 1'b0; la = 2'd0; lb = 2'd0;
    run(3);
    rst_in = 1'b0;
    run(500);

    // single request, full 0 -> 3 ramp
    ra = 1'b1; la = 2'd3;
    run(450);

    // simultaneous pair from reset: A first, then B; then B wins the next tie
    rst_in = 1'b1;
    run(2);
    rst_in = 1'b0;
    ra = 1'b1; la = 2'd2; rb = 1'b1; lb = 2'd1;
    run(520);
    ra = 1'b1; la = 2'd3; rb = 1'b1; lb = 2'd0;
    run(650);

    // level equal to current mode
    ra = 1'b1; la = 2'd3;
    run(10);

    // B arrives mid-ramp of A
    ra = 1'b1; la = 2'd0;
    run(5);
    rb = 1'b1; lb = 2'd2;
    run(800);

    // reset while ramping 2 -> 3, then a fresh request
    ra = 1'b1; la = 2'd3;
    run(60);
    rst_in = 1'b1; ra = 1'b0; rb = 1'b0;
    run(1);
    rst_in = 1'b0;
    rb = 1'b1; lb = 2'd1;
    run(200);

    // random traffic with occasional reset
    for (int i = 0; i < 20000; i++) begin
      if (!ra && $urandom_range(0, 39) == 0) begin
        la = 2'($urandom_range(0, 3));
        ra = 1'b1;
      end
      if (!rb && $urandom_range(0, 39) == 0) begin
        lb = 2'($urandom_range(0, 3));
        rb = 1'b1;
      end
      if ($urandom_range(0, 4999) == 0) begin
        rst_in = 1'b1; ra = 1'b0; rb = 1'b0;
        step();
        rst_in = 1'b0;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pwm_ramp_controller.md
# pwm_ramp_controller

Controller that owns the 2-bit `mode` input of the 32-tick PWM pulse generator. It arbitrates level-change requests from two requesters. It then ramps `mode` one duty step at a time toward the granted target, and changes `mode` only on PWM period boundaries so the generator never sees a mid-period duty change. It sits between the requesters (host register, button logic) and the pulse generator, and is reset by the same `rst` as the generator.

## Interface
- `PERIOD`, default 32: clocks per PWM period; must equal the generator's counter modulus.
- `STEP_PERIODS`, default 4: PWM periods per ramp step; range 1..255.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_a` in 1: requester A level-change request, held until `ack_a`.
- `lvl_a` in 2: requester A target level (0=0%, 1=25%, 2=50%, 3=75%); stable while `req_a` is high.
- `req_b` in 1: requester B request, same rules as A.
- `lvl_b` in 2: requester B target level.
- `ack_a` out 1: one-cycle grant pulse to A.
- `ack_b` out 1: one-cycle grant pulse to B.
- `mode` out 2: duty level driven to the pulse generator's `mode`.
- `busy` out 1: high from grant until the ramp completes.
- `done` out 1: one-cycle pulse when `mode` reaches the target.

## Operation
- Period counter `pcnt` counts 0..PERIOD-1 and wraps; it is 0 after reset, so it stays aligned with the generator's counter. A boundary is the cycle with `pcnt==PERIOD-1`.
- Step counter `scnt` counts boundaries 0..STEP_PERIODS-1. It clears on grant.
- FSM states:
  - IDLE: `busy`=0. On `req_a|req_b`, go to GRANT, latch the winner's level into `target`, and set the rr pointer to the loser.
  - GRANT: pulse the winner's ack and set `busy`=1. If `target==mode`, go to DONE. Otherwise go to RAMP.
  - RAMP: on a boundary with `scnt==STEP_PERIODS-1`, step `mode` by ±1 toward `target` and clear `scnt`. On other boundaries, increment `scnt`. When the updated `mode==target`, go to DONE.
  - DONE: pulse `done`, set `busy`=0, return to IDLE.
- Arbitration:
  - A single request is granted directly.
  - If both requests are high, the rr pointer decides.
  - The rr pointer favours A after reset and toggles only on simultaneous requests.
- Requests that arrive outside IDLE are not acked. They stay pending, because the requester holds `req`, and are evaluated on return to IDLE.
- `mode` moves only in ±1 steps, saturating at 0 and 3 with no wrap. It never changes except on a boundary.
- `target` is a 2-bit register that is never modified during RAMP.
- Reset values: `mode`=0, `ack_a`=`ack_b`=0, `busy`=0, `done`=0, state IDLE, `pcnt`=`scnt`=0, rr pointer favours A.

## Timing
- All outputs are registered.
- `req` is sampled in IDLE at edge N. State is GRANT after N, and `ack` is high during cycle N+1 only.
- The first ramp step lands at the STEP_PERIODS-th boundary after GRANT. `mode` changes at the edge that wraps `pcnt` to 0, so the generator's new period uses the new width.
- Ramp length is |target−mode_at_grant|×STEP_PERIODS boundaries, measured from GRANT.
- `done` is high the cycle after the final `mode` update. If no ramp was needed, `done` is high the cycle after GRANT.
- A requester may start its next request in the cycle after `ack`. The earliest next grant comes after DONE, in IDLE.
- `rst` asserted mid-ramp: `mode`=0 at the next edge with no partial step, and any in-flight ack/done is suppressed.
- `rst` held high: `pcnt` stays 0.

## Test plan
- Reset then idle, PERIOD=32, STEP_PERIODS=4: `mode`=0, `busy`=0, and no ack for 500 cycles.
- A requests level 3 from `mode`=0:
  - `ack_a` lasts 1 cycle.
  - `mode` becomes 1, 2, then 3, each change landing at an edge where `pcnt` wraps to 0.
  - The changes are 128 cycles apart.
  - `done` pulses once, after which `busy`=0.
- Simultaneous `req_a`(lvl 2) and `req_b`(lvl 1) from reset:
  - A is granted first.
  - B stays pending and is acked after A's DONE.
  - `mode` ends at 1, having stepped 0→1→2→1.
  - A repeated simultaneous pair is then granted to B first.
- Request for a level equal to the current `mode`: ack, then `done` the next cycle, `busy` high for exactly 2 cycles, and no `mode` change.
- `req_b` raised during A's ramp: no `ack_b` until A's `done`; `ack_b` arrives within 2 cycles after `done`.
- `rst` pulsed while `mode`=2 and ramping to 3: `mode`=0 and `busy`=0 the next cycle, no `done`, and a new request is handled normally.
